i2s_rx: RTL and testbench

//  Slave-mode I2S receiver: deserializes codec ADC data (mic/line-in) clocked by external sclk/lrclk,

---
 rtl/i2s_pkg.sv | 28 ++
 rtl/i2s_rx_fifo.sv | 54 +++++
 rtl/i2s_rx.sv | 209 ++++++++++++++++++++
 tb/tb_i2s_rx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S receive path.
package i2s_pkg;

   localparam int I2S_DEFAULT_WIDTH = 16;

   // Avalon-MM register word addresses
   localparam logic [1:0] I2S_CTRL   = 2'd0;
   localparam logic [1:0] I2S_STATUS = 2'd1;
   localparam logic [1:0] I2S_DATA_L = 2'd2;
   localparam logic [1:0] I2S_DATA_R = 2'd3;

   // CTRL bit positions
   localparam int CTRL_ENABLE = 0;
   localparam int CTRL_CLEAR  = 1;

   // STATUS bit positions
   localparam int ST_EMPTY     = 0;
   localparam int ST_FULL      = 1;
   localparam int ST_OVERFLOW  = 2;
   localparam int ST_COUNT_LSB = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_L = 2'd1,
      SHIFT  = 2'd2
   } rx_state_t;

endpackage

// File: rtl/i2s_rx_fifo.sv
// Synchronous FIFO holding packed {left, right} stereo pairs.
// A push while full is dropped unless a pop frees a slot in the same cycle.
// Clear empties the FIFO and overrides any same-cycle push or pop.
module i2s_rx_fifo #(
   parameter int DW    = 32,
   parameter int DEPTH = 8
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [DW-1:0]            din,
   output logic [DW-1:0]            dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty && !clear;
   assign push_ok = push && !clear && (!full || pop_ok);
   assign dout    = mem[rd_ptr];

   // Storage write; contents are only observed through the count-qualified head.
   always_ff @(posedge CLK) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
   always_ff @(posedge CLK) begin
      if (RESET || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop_ok)      count <= count + 1'b1;
         else if (pop_ok && !push_ok) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/i2s_rx.sv
// Slave-mode I2S receiver with Avalon-MM register access.
//
// state  | meaning
// IDLE   | receiver disabled, nothing captured
// WAIT_L | enabled, waiting for a right-to-left word-select transition
// SHIFT  | framed; shifting slot bits and closing slots at lrclk changes
//
// The rise that shows a new lrclk value is the I2S delay bit and is never
// shifted in; a slot is good only if it delivered at least WIDTH data bits.
module i2s_rx
   import i2s_pkg::*;
#(
   parameter int WIDTH = I2S_DEFAULT_WIDTH,
   parameter int DEPTH = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              sclk,
   input  logic              lrclk,
   input  logic              data_in,
   input  logic              AVL_READ,
   input  logic              AVL_WRITE,
   input  logic              AVL_CS,
   input  logic [3:0]        AVL_BYTE_EN,
   input  logic [1:0]        AVL_ADDR,
   input  logic [31:0]       AVL_WRITEDATA,
   output logic [31:0]       AVL_READDATA,
   output logic              sample_valid,
   output logic [WIDTH-1:0]  left_sample,
   output logic [WIDTH-1:0]  right_sample
);

   localparam int CNTW = $clog2(WIDTH + 1);
   localparam int CW   = $clog2(DEPTH) + 1;
   localparam logic [CNTW-1:0] CNT_FULL = CNTW'(WIDTH);

   logic sclk_s1, sclk_s2, sclk_s3;
   logic lr_s1, lr_s2;
   logic data_s1, data_s2;
   logic rise;

   rx_state_t        state;
   logic             chan_r;
   logic [CNTW-1:0]  cnt;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] l_cap;
   logic             l_good;
   logic             lr_prev;
   logic             fifo_push;

   logic             enable;
   logic             overflow;
   logic             ctrl_wr;
   logic             status_wr;
   logic             fifo_clear;
   logic             rd_en;
   logic             rd_pop;
   logic             drop;

   logic [2*WIDTH-1:0] fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CW-1:0]      fifo_count;
   logic [WIDTH-1:0]   head_l;
   logic [WIDTH-1:0]   head_r;
   logic [31:0]        status_word;

   logic unused_bits;
   assign unused_bits = &{1'b0, AVL_BYTE_EN[3:1], AVL_WRITEDATA[31:3]};

   // Bring the codec clocks and data into the CLK domain; extra sclk stage for edge detect.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_s3 <= 1'b0;
         lr_s1   <= 1'b0; lr_s2   <= 1'b0;
         data_s1 <= 1'b0; data_s2 <= 1'b0;
      end else begin
         sclk_s1 <= sclk;    sclk_s2 <= sclk_s1; sclk_s3 <= sclk_s2;
         lr_s1   <= lrclk;   lr_s2   <= lr_s1;
         data_s1 <= data_in; data_s2 <= data_s1;
      end
   end

   assign rise = sclk_s2 & ~sclk_s3;

   // Deserializer FSM: frames on lrclk, assembles L/R words, emits complete pairs.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state        <= IDLE;
         chan_r       <= 1'b0;
         cnt          <= '0;
         sreg         <= '0;
         l_cap        <= '0;
         l_good       <= 1'b0;
         lr_prev      <= 1'b0;
         fifo_push    <= 1'b0;
         sample_valid <= 1'b0;
         left_sample  <= '0;
         right_sample <= '0;
      end else begin
         fifo_push    <= 1'b0;
         sample_valid <= 1'b0;
         if (rise) lr_prev <= lr_s2;
         if (!enable) begin
            state  <= IDLE;
            chan_r <= 1'b0;
            cnt    <= '0;
            l_good <= 1'b0;
         end else if (rise) begin
            case (state)
               IDLE: state <= WAIT_L;
               WAIT_L: begin
                  if (!lr_s2 && lr_prev) begin
                     state  <= SHIFT;
                     chan_r <= 1'b0;
                     cnt    <= '0;
                     l_good <= 1'b0;
                  end
               end
               SHIFT: begin
                  if (lr_s2 != lr_prev) begin
                     if (!chan_r) begin
                        l_cap  <= sreg;
                        l_good <= (cnt == CNT_FULL);
                        chan_r <= 1'b1;
                     end else begin
                        if (l_good && (cnt == CNT_FULL)) begin
                           left_sample  <= l_cap;
                           right_sample <= sreg;
                           fifo_push    <= 1'b1;
                           sample_valid <= 1'b1;
                        end
                        l_good <= 1'b0;
                        chan_r <= 1'b0;
                     end
                     cnt <= '0;
                  end else if (cnt < CNT_FULL) begin
                     sreg <= {sreg[WIDTH-2:0], data_s2};
                     cnt  <= cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign ctrl_wr    = AVL_WRITE && AVL_CS && AVL_BYTE_EN[0] && (AVL_ADDR == I2S_CTRL);
   assign status_wr  = AVL_WRITE && AVL_CS && AVL_BYTE_EN[0] && (AVL_ADDR == I2S_STATUS);
   assign fifo_clear = ctrl_wr && AVL_WRITEDATA[CTRL_CLEAR];
   assign rd_en      = AVL_READ && AVL_CS;
   assign rd_pop     = rd_en && (AVL_ADDR == I2S_DATA_R) && !fifo_empty;
   assign drop       = fifo_push && fifo_full && !fifo_clear && !rd_pop;

   i2s_rx_fifo #(
      .DW    (2*WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .RESET (RESET),
      .push  (fifo_push),
      .pop   (rd_pop),
      .clear (fifo_clear),
      .din   ({left_sample, right_sample}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign head_l = fifo_dout[2*WIDTH-1:WIDTH];
   assign head_r = fifo_dout[WIDTH-1:0];

   // Control register and sticky overflow flag.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         enable   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (ctrl_wr) enable <= AVL_WRITEDATA[CTRL_ENABLE];
         if (drop) overflow <= 1'b1;
         else if (status_wr && AVL_WRITEDATA[ST_OVERFLOW]) overflow <= 1'b0;
      end
   end

   // STATUS word assembly.
   always_comb begin
      status_word = '0;
      status_word[ST_EMPTY]    = fifo_empty;
      status_word[ST_FULL]     = fifo_full;
      status_word[ST_OVERFLOW] = overflow;
      status_word[ST_COUNT_LSB +: 8] = 8'(fifo_count);
   end

   // Registered read data; sample reads are sign-extended and gated to 0 when empty.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         AVL_READDATA <= '0;
      end else if (rd_en) begin
         case (AVL_ADDR)
            I2S_CTRL:   AVL_READDATA <= {31'b0, enable};
            I2S_STATUS: AVL_READDATA <= status_word;
            I2S_DATA_L: AVL_READDATA <= fifo_empty ? 32'b0 : {{(32-WIDTH){head_l[WIDTH-1]}}, head_l};
            default:    AVL_READDATA <= fifo_empty ? 32'b0 : {{(32-WIDTH){head_r[WIDTH-1]}}, head_r};
         endcase
      end
   end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: codec frames driven on sclk/lrclk/data_in,
// results checked through the Avalon registers and sample outputs.
module tb_i2s_rx;

   localparam int W = 16;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        sclk, lrclk, data_in;
   logic        AVL_READ, AVL_WRITE, AVL_CS;
   logic [3:0]  AVL_BYTE_EN;
   logic [1:0]  AVL_ADDR;
   logic [31:0] AVL_WRITEDATA;
   logic [31:0] AVL_READDATA;
   logic        sample_valid;
   logic [W-1:0] left_sample, right_sample;

   int n_checks = 0;
   int n_fail   = 0;
   int sv_cnt   = 0;

   typedef struct {
      logic [1:0]  addr;
      logic [31:0] exp;
   } rd_vec_t;

   rd_vec_t vecs [17];

   i2s_rx #(.WIDTH(W), .DEPTH(8)) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .sclk          (sclk),
      .lrclk         (lrclk),
      .data_in       (data_in),
      .AVL_READ      (AVL_READ),
      .AVL_WRITE     (AVL_WRITE),
      .AVL_CS        (AVL_CS),
      .AVL_BYTE_EN   (AVL_BYTE_EN),
      .AVL_ADDR      (AVL_ADDR),
      .AVL_WRITEDATA (AVL_WRITEDATA),
      .AVL_READDATA  (AVL_READDATA),
      .sample_valid  (sample_valid),
      .left_sample   (left_sample),
      .right_sample  (right_sample)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) if (sample_valid) sv_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One sclk period = 8 CLK; lrclk/data change with the falling sclk edge.
   // Rise 0 carries the lrclk change (delay bit), rises 1..W carry word MSB first,
   // later rises carry 1s that must be ignored.
   task automatic send_bits(input logic lr, input logic [W-1:0] word, input int n);
      for (int k = 0; k < n; k++) begin
         sclk  = 1'b0;
         lrclk = lr;
         if (k == 0)      data_in = 1'b0;
         else if (k <= W) data_in = word[W-k];
         else             data_in = 1'b1;
         repeat (4) @(negedge CLK);
         sclk = 1'b1;
         repeat (4) @(negedge CLK);
      end
   endtask

   task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int n);
      send_bits(1'b0, l, n);
      send_bits(1'b1, r, n);
   endtask

   // Closes the previous right slot so its pair is pushed, then parks in a short right slot.
   task automatic lead_out();
      send_bits(1'b0, '0, 1);
      send_bits(1'b1, '0, 2);
   endtask

   task automatic avl_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge CLK);
      AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
      AVL_WRITE = 1'b1; AVL_CS = 1'b1;
      @(negedge CLK);
      AVL_WRITE = 1'b0; AVL_CS = 1'b0; AVL_BYTE_EN = 4'h0;
   endtask

   task automatic avl_read_now(input logic [1:0] a, output logic [31:0] d);
      AVL_ADDR = a; AVL_READ = 1'b1; AVL_CS = 1'b1;
      @(negedge CLK);
      AVL_READ = 1'b0; AVL_CS = 1'b0;
      d = AVL_READDATA;
   endtask

   task automatic avl_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge CLK);
      avl_read_now(a, d);
   endtask

   task automatic check_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] d;
      avl_read(a, d);
      check(name, d, exp);
   endtask

   initial begin
      logic [31:0] d;
      int base;
      bit  seen;

      // Readback table for the overflow test: frames 1..8 survive, frame 9 is dropped.
      vecs[0]  = '{2'd2, 32'h0000_1101}; vecs[1]  = '{2'd3, 32'hFFFF_9201};
      vecs[2]  = '{2'd2, 32'h0000_1102}; vecs[3]  = '{2'd3, 32'hFFFF_9202};
      vecs[4]  = '{2'd2, 32'h0000_1103}; vecs[5]  = '{2'd3, 32'hFFFF_9203};
      vecs[6]  = '{2'd2, 32'h0000_1104}; vecs[7]  = '{2'd3, 32'hFFFF_9204};
      vecs[8]  = '{2'd2, 32'h0000_1105}; vecs[9]  = '{2'd3, 32'hFFFF_9205};
      vecs[10] = '{2'd2, 32'h0000_1106}; vecs[11] = '{2'd3, 32'hFFFF_9206};
      vecs[12] = '{2'd2, 32'h0000_1107}; vecs[13] = '{2'd3, 32'hFFFF_9207};
      vecs[14] = '{2'd2, 32'h0000_1108}; vecs[15] = '{2'd3, 32'hFFFF_9208};
      vecs[16] = '{2'd1, 32'h0000_0001};

      RESET = 1'b1; sclk = 1'b0; lrclk = 1'b0; data_in = 1'b0;
      AVL_READ = 1'b0; AVL_WRITE = 1'b0; AVL_CS = 1'b0;
      AVL_BYTE_EN = 4'h0; AVL_ADDR = 2'd0; AVL_WRITEDATA = '0;
      repeat (3) @(negedge CLK);
      RESET = 1'b0;

      // Reset state
      check("rst_readdata", AVL_READDATA, 32'h0);
      check("rst_valid", {31'b0, sample_valid}, 32'h0);
      check("rst_left", {16'b0, left_sample}, 32'h0);
      check("rst_right", {16'b0, right_sample}, 32'h0);
      check_reg("rst_ctrl", 2'd0, 32'h0);
      check_reg("rst_status", 2'd1, 32'h0000_0001);

      // Test 1: basic frames; byte-enable gating on CTRL
      avl_write(2'd0, 32'h1, 4'hF);
      avl_write(2'd0, 32'h0, 4'hE);
      check_reg("ctrl_be_gate", 2'd0, 32'h1);
      base = sv_cnt;
      send_bits(1'b1, '0, 3);
      send_frame(16'h1234, 16'hABCD, 17);
      send_frame(16'h1234, 16'hABCD, 17);
      lead_out();
      check("t1_valid_cnt", sv_cnt - base, 2);
      check("t1_left", {16'b0, left_sample}, 32'h0000_1234);
      check("t1_right", {16'b0, right_sample}, 32'h0000_ABCD);
      check_reg("t1_status2", 2'd1, 32'h0000_0200);
      check_reg("t1_data_l", 2'd2, 32'h0000_1234);
      check_reg("t1_data_r", 2'd3, 32'hFFFF_ABCD);
      check_reg("t1_data_l2", 2'd2, 32'h0000_1234);
      check_reg("t1_data_r2", 2'd3, 32'hFFFF_ABCD);
      check_reg("t1_status0", 2'd1, 32'h0000_0001);

      // Test 2: enable in the middle of a right slot
      avl_write(2'd0, 32'h0, 4'hF);
      base = sv_cnt;
      send_bits(1'b0, 16'h5555, 17);
      fork
         send_bits(1'b1, 16'h6666, 17);
         begin
            repeat (60) @(negedge CLK);
            avl_write(2'd0, 32'h1, 4'hF);
         end
      join
      send_frame(16'h0F0F, 16'h7E01, 17);
      lead_out();
      check("t2_valid_cnt", sv_cnt - base, 1);
      check_reg("t2_status", 2'd1, 32'h0000_0100);
      check_reg("t2_data_l", 2'd2, 32'h0000_0F0F);
      check_reg("t2_data_r", 2'd3, 32'h0000_7E01);

      // Test 3: nine frames, no reads -> overflow; frame 3 uses long slots
      base = sv_cnt;
      for (int i = 1; i <= 9; i++)
         send_frame(16'h1100 + 16'(i), 16'h9200 + 16'(i), (i == 3) ? 20 : 17);
      lead_out();
      check("t3_valid_cnt", sv_cnt - base, 9);
      check_reg("t3_status_ovf", 2'd1, 32'h0000_0806);
      avl_write(2'd1, 32'h4, 4'hF);
      check_reg("t3_status_clr", 2'd1, 32'h0000_0802);
      for (int i = 0; i < 17; i++) begin
         avl_read(vecs[i].addr, d);
         check($sformatf("t3_vec%0d", i), d, vecs[i].exp);
      end

      // Test 4: empty read, fifo_clear, read+push in the same cycle
      check_reg("t4_empty_read", 2'd3, 32'h0);
      check_reg("t4_empty_status", 2'd1, 32'h0000_0001);
      send_frame(16'h0101, 16'h0202, 17);
      send_frame(16'h0303, 16'h0404, 17);
      lead_out();
      check_reg("t4_pre_clear", 2'd1, 32'h0000_0200);
      avl_write(2'd0, 32'h3, 4'hF);
      check_reg("t4_post_clear", 2'd1, 32'h0000_0001);
      check_reg("t4_ctrl_after_clr", 2'd0, 32'h1);
      send_frame(16'h0A01, 16'h0B01, 17);
      send_frame(16'h0A02, 16'h0B02, 17);
      send_frame(16'h0A03, 16'h0B03, 17);
      lead_out();
      check_reg("t4_count3", 2'd1, 32'h0000_0300);
      fork
         begin
            send_frame(16'h0A04, 16'h0B04, 17);
            lead_out();
         end
         begin
            seen = 1'b0;
            for (int c = 0; c < 2000 && !seen; c++) begin
               @(negedge CLK);
               if (sample_valid) seen = 1'b1;
            end
            if (seen) begin
               avl_read_now(2'd3, d);
               check("t4_pushpop_data", d, 32'h0000_0B01);
            end else begin
               check("t4_push_timeout", 32'h0, 32'h1);
            end
         end
      join
      check_reg("t4_count_kept", 2'd1, 32'h0000_0300);
      check_reg("t4_head_l", 2'd2, 32'h0000_0A02);

      // Test 5: truncated left slot
      avl_write(2'd0, 32'h3, 4'hF);
      base = sv_cnt;
      send_bits(1'b0, 16'h1111, 10);
      send_bits(1'b1, 16'h2222, 17);
      send_frame(16'h3333, 16'h4444, 17);
      lead_out();
      check("t5_valid_cnt", sv_cnt - base, 1);
      check_reg("t5_status", 2'd1, 32'h0000_0100);
      check_reg("t5_data_l", 2'd2, 32'h0000_3333);
      check_reg("t5_data_r", 2'd3, 32'h0000_4444);

      // Test 6: reset mid-SHIFT
      send_frame(16'h7777, 16'h8888, 17);
      lead_out();
      check_reg("t6_pre_status", 2'd1, 32'h0000_0100);
      send_bits(1'b0, 16'h5A5A, 8);
      @(negedge CLK);
      RESET = 1'b1;
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      check("t6_left", {16'b0, left_sample}, 32'h0);
      check("t6_right", {16'b0, right_sample}, 32'h0);
      check("t6_readdata", AVL_READDATA, 32'h0);
      check_reg("t6_ctrl", 2'd0, 32'h0);
      base = sv_cnt;
      send_bits(1'b0, 16'h5A5A, 9);
      send_bits(1'b1, 16'hA5A5, 17);
      send_frame(16'h1357, 16'h2468, 17);
      lead_out();
      check("t6_valid_cnt", sv_cnt - base, 0);
      check_reg("t6_status", 2'd1, 32'h0000_0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
